// File: rtl/simplez_uart_port.sv
// simplez_uart_port: memory-mapped serial port for the Simplez CPU bus.
// Four registers at BASE_ADR..BASE_ADR+3: TX status, TX data, RX status, RX data.
// A TX shift engine drives tx. An RX sampler fills a small byte FIFO.
// Optional build macro SIMPLEZ_UART_LOOPBACK_EN feeds tx back into the RX
// synchroniser in place of the rx pin.
module simplez_uart_port #(
    parameter int BAUD     = 104,
    parameter int FIFO_AW  = 2,
    parameter int BASE_ADR = 508
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cs,
    input  logic        rw,
    input  logic [8:0]  addr,
    input  logic [11:0] data_in,
    output logic [11:0] data_out,
    input  logic        rx,
    output logic        tx,
    output logic        rx_avail
);
    localparam int CW = $clog2(BAUD);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD / 2 - 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus decode: offset wraps, so anything outside the 4-word window misses.
    logic [8:0] offset;
    logic       hit, tx_wr, pop_req, stat_rd;
    assign offset  = addr - 9'(BASE_ADR);
    assign hit     = cs && (offset[8:2] == 7'd0);
    assign tx_wr   = hit && !rw && (offset[1:0] == 2'd1);
    assign pop_req = hit && rw && (offset[1:0] == 2'd3);
    assign stat_rd = hit && rw && (offset[1:0] == 2'd2);

    logic unused_bits;
    assign unused_bits = ^data_in[11:8];

    // ---------------- TX engine ----------------
    state_t          tx_state, tx_state_nx;
    logic [CW-1:0]   tx_cnt, tx_cnt_nx;
    logic [2:0]      tx_bit, tx_bit_nx;
    logic [7:0]      tx_shift, tx_shift_nx;
    logic            tx_ready;

    // TX state register; async reset aborts any frame and idles tx at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
        end
    end

    // TX next-state and line drive; a write while busy falls through unused.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        tx          = 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (tx_wr) begin
                    tx_state_nx = S_START;
                    tx_cnt_nx   = '0;
                    tx_shift_nx = data_in[7:0];
                end
            end
            S_START: begin
                tx        = 1'b0;
                tx_cnt_nx = tx_cnt + CW'(1);
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_bit_nx   = 3'd0;
                    tx_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                tx        = tx_shift[0];
                tx_cnt_nx = tx_cnt + CW'(1);
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_shift_nx = {1'b0, tx_shift[7:1]};
                    tx_bit_nx   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_nx = S_STOP;
                end
            end
            default: begin
                tx        = 1'b1;
                tx_cnt_nx = tx_cnt + CW'(1);
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_state_nx = S_IDLE;
                end
            end
        endcase
    end

    assign tx_ready = (tx_state == S_IDLE);

    // ---------------- RX sampler ----------------
    logic rx_in;
`ifdef SIMPLEZ_UART_LOOPBACK_EN
    logic unused_rx;
    assign unused_rx = rx;
    assign rx_in = tx;
`else
    assign rx_in = rx;
`endif

    logic [1:0] rx_sync;
    logic       rx_s;
    assign rx_s = rx_sync[1];

    // Two-flop synchroniser, reset to the idle-high line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rx_sync <= 2'b11;
        else       rx_sync <= {rx_sync[0], rx_in};
    end

    state_t        rx_state, rx_state_nx;
    logic [CW-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]    rx_bit, rx_bit_nx;
    logic [7:0]    rx_shift, rx_shift_nx;
    logic          rx_wait, rx_wait_nx;
    logic          rx_push, ferr_set;

    // RX state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_wait  <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_shift <= rx_shift_nx;
            rx_wait  <= rx_wait_nx;
        end
    end

    // RX next-state: mid-bit sampling, glitch rejection, stop-bit check.
    // Idle is only reached with the line high, so low in IDLE is a falling edge.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_bit_nx   = rx_bit;
        rx_shift_nx = rx_shift;
        rx_wait_nx  = rx_wait;
        rx_push     = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!rx_s) begin
                    rx_state_nx = S_START;
                    rx_cnt_nx   = '0;
                end
            end
            S_START: begin
                rx_cnt_nx = rx_cnt + CW'(1);
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = 3'd0;
                    rx_state_nx = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                rx_cnt_nx = rx_cnt + CW'(1);
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_s, rx_shift[7:1]};
                    rx_bit_nx   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nx = S_STOP;
                end
            end
            default: begin
                if (rx_wait) begin
                    if (rx_s) begin
                        rx_wait_nx  = 1'b0;
                        rx_state_nx = S_IDLE;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CW'(1);
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt_nx = '0;
                        if (rx_s) begin
                            rx_push     = 1'b1;
                            rx_state_nx = S_IDLE;
                        end else begin
                            ferr_set   = 1'b1;
                            rx_wait_nx = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // ---------------- RX FIFO and flags ----------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               not_empty, full, pop_ok, push_ok, ovr_set;
    logic               overrun, ferr;
    logic [7:0]         head;

    assign not_empty = (count != '0);
    assign full      = (count == (FIFO_AW + 1)'(DEPTH));
    assign pop_ok    = pop_req && not_empty;
    // A pop in the same cycle frees the slot first, so a full FIFO still accepts.
    assign push_ok   = rx_push && (!full || pop_ok);
    assign ovr_set   = rx_push && !push_ok;
    assign head      = not_empty ? mem[rd_ptr] : 8'h00;
    assign rx_avail  = not_empty;

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_shift;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + (FIFO_AW + 1)'(push_ok) - (FIFO_AW + 1)'(pop_ok);
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            overrun <= ovr_set  | (overrun & ~stat_rd);
            ferr    <= ferr_set | (ferr & ~stat_rd);
        end
    end

    // ---------------- Read path ----------------
    logic [11:0] rd_data;

    // Register read mux; non-hits read as zero.
    always_comb begin
        rd_data = 12'h000;
        if (hit) begin
            case (offset[1:0])
                2'd0:    rd_data = {11'b0, tx_ready};
                2'd2:    rd_data = {9'b0, ferr, overrun, not_empty};
                2'd3:    rd_data = {4'b0, head};
                default: rd_data = 12'h000;
            endcase
        end
    end

    // Registered read data, held until the next read access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         data_out <= 12'h000;
        else if (cs && rw) data_out <= rd_data;
    end
endmodule

// File: tb/tb_simplez_uart_port.sv
// Bench for simplez_uart_port at BAUD=4, depth-4 FIFO.
// Reference: expected tx frames are built as {stop, byte, start} vectors and
// the receive side is a byte queue with overrun/framing flags.
module tb_simplez_uart_port;
    localparam int BAUD = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cs = 1'b0;
    logic        rw = 1'b0;
    logic [8:0]  addr = '0;
    logic [11:0] data_in = '0;
    logic [11:0] data_out;
    logic        rx = 1'b1;
    logic        tx;
    logic        rx_avail;

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    simplez_uart_port #(.BAUD(BAUD), .FIFO_AW(2), .BASE_ADR(508)) dut (
        .clk(clk), .rstn(rstn), .cs(cs), .rw(rw), .addr(addr),
        .data_in(data_in), .data_out(data_out), .rx(rx), .tx(tx),
        .rx_avail(rx_avail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [8:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; addr = a; data_in = {4'h0, d};
        tick(1);
        cs = 1'b0;
    endtask

    task automatic read_check(input logic [8:0] a, input logic [11:0] exp, input string tag);
        cs = 1'b1; rw = 1'b1; addr = a;
        tick(1);
        cs = 1'b0;
        check(tag, data_out, exp);
    endtask

    // Status read against the model; the read clears the sticky flags.
    task automatic status_check(input string tag);
        logic [11:0] exp;
        exp = {9'b0, m_ferr, m_ovr, exp_q.size() != 0};
        read_check(9'd510, exp, tag);
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [11:0] exp;
        exp = 12'h000;
        if (exp_q.size() != 0) exp = {4'h0, exp_q.pop_front()};
        read_check(9'd511, exp, tag);
    endtask

    // Write a byte and watch the whole frame; optionally attempt a second write.
    task automatic tx_frame(input logic [7:0] b, input int second_at, input logic [7:0] b2,
                            input string tag);
        logic [9:0] frame;
        int bad;
        frame = {1'b1, b, 1'b0};
        bad = 0;
        bus_write(9'd509, b);
        for (int i = 0; i < 10 * BAUD; i++) begin
            if (tx !== frame[i / BAUD]) bad++;
            if (i == second_at) begin
                cs = 1'b1; rw = 1'b0; addr = 9'd509; data_in = {4'h0, b2};
            end
            if (i == 10 * BAUD - 1) begin
                cs = 1'b1; rw = 1'b1; addr = 9'd508;
            end
            tick(1);
            cs = 1'b0;
        end
        check({tag, " bit_errors"}, 12'(bad), 12'h000);
        check({tag, " ready_in_stop"}, data_out, 12'h000);
        check({tag, " tx_idle"}, 12'(tx), 12'h001);
        read_check(9'd508, 12'h001, {tag, " ready_after"});
    endtask

    // Drive one serial frame on rx and update the receive model.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BAUD);
        end
        rx = stop;
        tick(BAUD);
        rx = 1'b1;
        tick(6);
        if (!stop) m_ferr = 1'b1;
        else if (exp_q.size() == DEPTH) m_ovr = 1'b1;
        else exp_q.push_back(b);
    endtask

    initial begin
        int k;
        logic [7:0] b;

        // Reset state
        tick(3);
        check("reset tx", 12'(tx), 12'h001);
        check("reset rx_avail", 12'(rx_avail), 12'h000);
        check("reset data_out", data_out, 12'h000);
        rstn = 1'b1;
        tick(2);
        read_check(9'd508, 12'h001, "reset tx_ready");
        status_check("reset rx_status");

`ifdef SIMPLEZ_UART_LOOPBACK_EN
        // Loopback: written byte returns through the receiver
        bus_write(9'd509, 8'h7E);
        tick(10 * BAUD + 8);
        check("loop rx_avail", 12'(rx_avail), 12'h001);
        read_check(9'd511, 12'h07E, "loop rx_data");
        check("loop rx_avail after pop", 12'(rx_avail), 12'h000);
`else
        // TX frames
        tx_frame(8'h55, -1, 8'h00, "tx55");
        for (int r = 0; r < 3; r++) begin
            b = 8'($urandom_range(0, 255));
            tx_frame(b, -1, 8'h00, "tx_rand");
        end
        tx_frame(8'hA3, 1, 8'h11, "tx_busy");

        // Read side effects and misses
        read_check(9'd509, 12'h000, "tx_data reads zero");
        read_check(9'd508, 12'h001, "tx_status");
        tick(4);
        check("data_out hold", data_out, 12'h001);
        read_check(9'd300, 12'h000, "miss reads zero");

        // Single RX byte
        send_rx(8'h3C, 1'b1);
        check("rx3c avail", 12'(rx_avail), 12'h001);
        status_check("rx3c status");
        pop_check("rx3c data");
        check("rx3c avail after pop", 12'(rx_avail), 12'h000);
        status_check("rx3c status empty");
        pop_check("pop empty");

        // Overflow with five frames
        for (int j = 1; j <= 5; j++) send_rx(8'(j), 1'b1);
        status_check("ovf status");
        for (int j = 0; j < 4; j++) pop_check("ovf data");
        status_check("ovf status cleared");

        // Randomized bursts with full drain
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) send_rx(8'($urandom_range(0, 255)), 1'b1);
            check("rand avail", 12'(rx_avail), 12'(exp_q.size() != 0));
            status_check("rand status");
            for (int j = 0; j < 5; j++) pop_check("rand data");
            status_check("rand status drained");
        end

        // Framing error and glitch
        send_rx(8'h5A, 1'b0);
        check("ferr avail", 12'(rx_avail), 12'h000);
        status_check("ferr status");
        status_check("ferr cleared");
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        check("glitch avail", 12'(rx_avail), 12'h000);
        status_check("glitch status");

        // Put a byte in the FIFO so reset has something to clear
        send_rx(8'h9A, 1'b1);
        check("prereset avail", 12'(rx_avail), 12'h001);
`endif

        // Reset in the middle of a TX frame
        bus_write(9'd509, 8'hF0);
        tick(7);
        rstn = 1'b0;
        #1;
        check("midreset tx", 12'(tx), 12'h001);
        check("midreset rx_avail", 12'(rx_avail), 12'h000);
        check("midreset data_out", data_out, 12'h000);
        exp_q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        #2;
        rstn = 1'b1;
        tick(1);
        read_check(9'd508, 12'h001, "postreset tx_ready");
        status_check("postreset status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
